// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: program-load, control and fetched-instruction signals of the fetch stage
interface instruction_fetch_if #(
    parameter int MEM_DEPTH = 256
);
    localparam int AW = $clog2(MEM_DEPTH);
    logic          loadEnable;
    logic [AW-1:0] loadAddr;
    logic [31:0]   loadData;
    logic          start;
    logic          stall;
    logic          branchFlag;
    logic          unconditionalBranchFlag;
    logic          zeroFlag;
    logic [31:0]   branchOffset;
    logic [31:0]   instruction;
    logic [31:0]   pc;
    logic          instructionValid;
    logic          halted;
    modport master (
        output loadEnable, loadAddr, loadData, start, stall,
               branchFlag, unconditionalBranchFlag, zeroFlag, branchOffset,
        input  instruction, pc, instructionValid, halted
    );
    modport slave (
        input  loadEnable, loadAddr, loadData, start, stall,
               branchFlag, unconditionalBranchFlag, zeroFlag, branchOffset,
        output instruction, pc, instructionValid, halted
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, word-addressed instruction memory and next-PC selection feeding decode
module instruction_fetch #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input logic                clk,
    input logic                reset,
    instruction_fetch_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] RESET_IDX = RESET_PC[AW+1:2];

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    logic [31:0] mem [MEM_DEPTH];
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d;
    logic        valid_q, valid_d, halted_q, halted_d;
    logic        taken, out_of_range;
    logic [31:0] next_pc;

    always_ff @(posedge clk)
        if (state_q == IDLE && bus.loadEnable) mem[bus.loadAddr] <= bus.loadData;

    always_comb begin
        taken        = bus.unconditionalBranchFlag | (bus.branchFlag & bus.zeroFlag);
        next_pc      = pc_q + (taken ? bus.branchOffset << 2 : 32'd4);
        // a negative offset larger than pc shows up as an unsigned increase
        out_of_range = (|next_pc[31:AW+2]) | (taken & bus.branchOffset[31] & (next_pc > pc_q));
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                pc_d    = RESET_PC;
                instr_d = (bus.loadEnable && bus.loadAddr == RESET_IDX) ? bus.loadData : mem[RESET_IDX];
                valid_d = 1'b1;
            end
            RUN: if (!bus.stall) begin
                pc_d     = next_pc;
                state_d  = out_of_range ? HALT : RUN;
                instr_d  = out_of_range ? 32'd0 : mem[next_pc[AW+1:2]];
                valid_d  = !out_of_range;
                halted_d = out_of_range;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign bus.instruction      = instr_q;
    assign bus.pc               = pc_q;
    assign bus.instructionValid = valid_q;
    assign bus.halted           = halted_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of load, start, branching, stall, halt and reset
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic reset, reset4;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_if #(.MEM_DEPTH(256)) b ();
    instruction_fetch_if #(.MEM_DEPTH(4))   b4 ();

    instruction_fetch #(.MEM_DEPTH(256), .RESET_PC(32'd0)) dut  (.clk(clk), .reset(reset),  .bus(b));
    instruction_fetch #(.MEM_DEPTH(4),   .RESET_PC(32'd0)) dut4 (.clk(clk), .reset(reset4), .bus(b4));

    logic [31:0] w [8] = '{32'h10400000, 32'h08000000, 32'h18000000, 32'h10000000,
                           32'h20000004, 32'h20000005, 32'h20000006, 32'h20000007};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp256(input string tag, input logic [31:0] ep, input logic [31:0] ei,
                          input logic ev, input logic eh);
        chk({tag, ".pc"}, b.pc, ep);
        chk({tag, ".instr"}, b.instruction, ei);
        chk({tag, ".valid"}, {31'd0, b.instructionValid}, {31'd0, ev});
        chk({tag, ".halted"}, {31'd0, b.halted}, {31'd0, eh});
    endtask

    task automatic exp4(input string tag, input logic [31:0] ep, input logic [31:0] ei,
                        input logic ev, input logic eh);
        chk({tag, ".pc"}, b4.pc, ep);
        chk({tag, ".instr"}, b4.instruction, ei);
        chk({tag, ".valid"}, {31'd0, b4.instructionValid}, {31'd0, ev});
        chk({tag, ".halted"}, {31'd0, b4.halted}, {31'd0, eh});
    endtask

    task automatic br(input logic u, input logic c, input logic z, input logic [31:0] off);
        b.unconditionalBranchFlag = u;
        b.branchFlag = c;
        b.zeroFlag = z;
        b.branchOffset = off;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; reset4 = 1'b1;
        b.loadEnable = 0; b.loadAddr = '0; b.loadData = '0; b.start = 0; b.stall = 0;
        br(0, 0, 0, 0);
        b4.loadEnable = 0; b4.loadAddr = '0; b4.loadData = '0; b4.start = 0; b4.stall = 0;
        b4.branchFlag = 0; b4.unconditionalBranchFlag = 0; b4.zeroFlag = 0; b4.branchOffset = 0;
        tick; tick;
        exp256("reset", 32'd0, 32'd0, 0, 0);
        reset = 1'b0;
        for (int i = 1; i < 8; i++) begin
            b.loadEnable = 1; b.loadAddr = 8'(i); b.loadData = w[i];
            tick;
        end
        exp256("idle_after_load", 32'd0, 32'd0, 0, 0);
        // mem[0] is written on the same edge as start and must be bypassed
        b.loadAddr = 8'd0; b.loadData = w[0]; b.start = 1;
        tick;
        b.loadEnable = 0; b.start = 0;
        exp256("start", 32'd0, w[0], 1, 0);
        tick; exp256("seq4", 32'd4, w[1], 1, 0);
        tick; exp256("seq8", 32'd8, w[2], 1, 0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp256("reset_mid_run", 32'd0, 32'd0, 0, 0);
        tick; exp256("idle_hold", 32'd0, 32'd0, 0, 0);
        b.start = 1;
        tick;
        b.start = 0;
        exp256("restart", 32'd0, w[0], 1, 0);
        tick; exp256("r4", 32'd4, w[1], 1, 0);
        br(1, 0, 0, 32'hFFFFFFFF);
        tick; br(0, 0, 0, 0);
        exp256("ubr_back", 32'd0, w[0], 1, 0);
        tick; exp256("after_ubr4", 32'd4, w[1], 1, 0);
        tick; exp256("after_ubr8", 32'd8, w[2], 1, 0);
        br(0, 1, 0, 32'd3);
        tick; br(0, 0, 0, 0);
        exp256("cbr_not_taken", 32'd12, w[3], 1, 0);
        tick; exp256("seq16", 32'd16, w[4], 1, 0);
        br(1, 0, 0, 32'hFFFFFFFE);
        tick; br(0, 0, 0, 0);
        exp256("ubr_to8", 32'd8, w[2], 1, 0);
        br(0, 1, 1, 32'd3);
        tick; br(0, 0, 0, 0);
        exp256("cbr_taken", 32'd20, w[5], 1, 0);
        br(1, 0, 0, 32'hFFFFFFFD);
        tick; br(0, 0, 0, 0);
        exp256("ubr_to8b", 32'd8, w[2], 1, 0);
        b.stall = 1; b.loadEnable = 1; b.loadAddr = 8'd3; b.loadData = 32'hDEADBEEF; b.start = 1;
        for (int i = 0; i < 3; i++) begin
            br(i[0], 1, 1, 32'd5 + 32'(i));
            tick;
            exp256($sformatf("stall%0d", i), 32'd8, w[2], 1, 0);
        end
        b.stall = 0; b.loadEnable = 0; b.start = 0;
        br(0, 0, 0, 0);
        tick; exp256("resume", 32'd12, w[3], 1, 0);
        br(1, 0, 0, 32'hFFFFFFFC);
        tick; br(0, 0, 0, 0);
        exp256("neg_wrap_halt", 32'hFFFFFFFC, 32'd0, 0, 1);
        tick; exp256("halt_hold", 32'hFFFFFFFC, 32'd0, 0, 1);

        tick;
        reset4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b4.loadEnable = 1; b4.loadAddr = 2'(i); b4.loadData = w[i];
            tick;
        end
        b4.loadEnable = 0; b4.start = 1;
        tick;
        b4.start = 0;
        exp4("d4_pc0", 32'd0, w[0], 1, 0);
        tick; exp4("d4_pc4", 32'd4, w[1], 1, 0);
        tick; exp4("d4_pc8", 32'd8, w[2], 1, 0);
        tick; exp4("d4_pc12", 32'd12, w[3], 1, 0);
        tick; exp4("d4_halt", 32'd16, 32'd0, 0, 1);
        b4.start = 1; b4.loadEnable = 1; b4.loadAddr = 2'd0; b4.loadData = 32'hCAFEF00D;
        tick; tick;
        b4.start = 0; b4.loadEnable = 0;
        exp4("d4_halt_ignores", 32'd16, 32'd0, 0, 1);
        reset4 = 1'b1;
        tick;
        reset4 = 1'b0;
        b4.start = 1;
        tick;
        b4.start = 0;
        exp4("d4_restart_unchanged", 32'd0, w[0], 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
